// File: rtl/div_seq_pkg.sv
// Shared encodings for the iterative divider: FSM state codes and the EX op codes
// that EX decodes into stall/start for the divider.
package div_seq_pkg;

    typedef logic [1:0] div_state_t;

    localparam div_state_t DIV_FREE    = 2'b00;
    localparam div_state_t DIV_BY_ZERO = 2'b01;
    localparam div_state_t DIV_ON      = 2'b10;
    localparam div_state_t DIV_END     = 2'b11;

    localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

    // EX raises start (and its stall request) for either divide flavour.
    function automatic logic is_div_op(input logic [7:0] aluop);
        return (aluop == EXE_DIV_OP) || (aluop == EXE_DIVU_OP);
    endfunction

endpackage

// File: rtl/div_seq_if.sv
// Request/response bundle between EX (master) and the iterative divider (slave).
interface div_seq_if #(parameter int WIDTH = 32);

    logic                 signed_div;
    logic [WIDTH-1:0]     opdata1;
    logic [WIDTH-1:0]     opdata2;
    logic                 start;
    logic                 annul;
    logic [2*WIDTH-1:0]   result;
    logic                 ready;

    modport master (
        output signed_div, opdata1, opdata2, start, annul,
        input  result, ready
    );

    modport slave (
        input  signed_div, opdata1, opdata2, start, annul,
        output result, ready
    );

endinterface

// File: rtl/div_seq.sv
// Radix-2 restoring divider for DIV/DIVU; one quotient bit per cycle, {rem, quo} result.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// FREE     | idle, waiting for start (annul wins over start)
// BY_ZERO  | divisor was zero; go to END with a zero result
// ON       | iterating, one restoring step per cycle, annul aborts
// END      | result/ready held while start stays high; start low -> FREE
import div_seq_pkg::*;

module div_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic      clk,
    input  logic      rst,
    div_seq_if.slave  bus
);

    div_state_t           state;
    logic [CNT_W-1:0]     cnt;
    logic [2*WIDTH-1:0]   work;
    logic [WIDTH-1:0]     divisor;
    logic                 neg_quo;
    logic                 neg_rem;
    logic [2*WIDTH-1:0]   result_q;
    logic                 ready_q;

    logic [WIDTH-1:0]     op1_mag;
    logic [WIDTH-1:0]     op2_mag;
    logic                 step_ge;
    logic [WIDTH-1:0]     step_diff;
    logic [2*WIDTH-1:0]   step_work;
    logic [WIDTH-1:0]     quo_fix;
    logic [WIDTH-1:0]     rem_fix;

    assign bus.result = result_q;
    assign bus.ready  = ready_q;

    // The trial window includes the next dividend bit, so the quotient bit shifted in
    // at the bottom lines up with the low half after WIDTH steps.
    always_comb begin
        op1_mag   = (bus.signed_div && bus.opdata1[WIDTH-1]) ? -bus.opdata1 : bus.opdata1;
        op2_mag   = (bus.signed_div && bus.opdata2[WIDTH-1]) ? -bus.opdata2 : bus.opdata2;
        step_ge   = work[2*WIDTH-1:WIDTH-1] >= {1'b0, divisor};
        step_diff = work[2*WIDTH-2:WIDTH-1] - divisor;
        step_work = step_ge ? {step_diff, work[WIDTH-2:0], 1'b1} : (work << 1);
        quo_fix   = neg_quo ? -work[WIDTH-1:0] : work[WIDTH-1:0];
        rem_fix   = neg_rem ? -work[2*WIDTH-1:WIDTH] : work[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= DIV_FREE;
            cnt      <= '0;
            work     <= '0;
            divisor  <= '0;
            neg_quo  <= 1'b0;
            neg_rem  <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            case (state)
                DIV_FREE: begin
                    ready_q  <= 1'b0;
                    result_q <= '0;
                    if (bus.start && !bus.annul) begin
                        if (bus.opdata2 == '0) begin
                            state <= DIV_BY_ZERO;
                        end else begin
                            state   <= DIV_ON;
                            cnt     <= '0;
                            work    <= {{WIDTH{1'b0}}, op1_mag};
                            divisor <= op2_mag;
                            neg_quo <= bus.signed_div && (bus.opdata1[WIDTH-1] ^ bus.opdata2[WIDTH-1]);
                            neg_rem <= bus.signed_div && bus.opdata1[WIDTH-1];
                        end
                    end
                end
                DIV_BY_ZERO: begin
                    if (bus.annul) begin
                        state <= DIV_FREE;
                    end else begin
                        state   <= DIV_END;
                        work    <= '0;
                        neg_quo <= 1'b0;
                        neg_rem <= 1'b0;
                    end
                end
                DIV_ON: begin
                    if (bus.annul) begin
                        state <= DIV_FREE;
                    end else begin
                        work <= step_work;
                        cnt  <= cnt + CNT_W'(1);
                        if (cnt == CNT_W'(WIDTH - 1))
                            state <= DIV_END;
                    end
                end
                default: begin
                    // END ignores annul: the result is already committed to HI/LO.
                    if (bus.start) begin
                        ready_q  <= 1'b1;
                        result_q <= {rem_fix, quo_fix};
                    end else begin
                        state    <= DIV_FREE;
                        ready_q  <= 1'b0;
                        result_q <= '0;
                    end
                end
            endcase
        end
    end

endmodule
